regfile_write_arbiter: RTL and testbench

- Shares the single register-file write port (we / addr_write2 / data_write2) between two writeback requesters: req0 (ALU/execute writeback) and req1 (load/memory writeback).
- Arbitrates with round-robin priority, registers the winning write for one cycle, and filters writes to x0.
- Exposes forwarding compare outputs so the read side can bypass the write that is in flight.
- Sits between the writeback sources and register_file. Its outputs connect directly to the register_file write inputs.

---
 rtl/regfile_write_arbiter.sv | 99 +++++++++
 tb/tb_regfile_write_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU and load
// writeback, with a one-cycle registered write stage, x0 filtering and forwarding.
module regfile_write_arbiter #(
  parameter int N    = 32,
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          req0_valid,
  input  logic [AW-1:0] req0_addr,
  input  logic [N-1:0]  req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [AW-1:0] req1_addr,
  input  logic [N-1:0]  req1_data,
  output logic          req1_ready,
  output logic          we,
  output logic [AW-1:0] addr_write2,
  output logic [N-1:0]  data_write2,
  output logic          grant_id,
  input  logic [AW-1:0] fwd_addr0,
  input  logic [AW-1:0] fwd_addr1,
  output logic          fwd_hit0,
  output logic          fwd_hit1,
  output logic [N-1:0]  fwd_data0,
  output logic [N-1:0]  fwd_data1
);

  logic          last_grant_reg;
  logic          we_reg;
  logic [AW-1:0] addr_reg;
  logic [N-1:0]  data_reg;
  logic          grant_reg;

  logic          hs0;
  logic          hs1;

  // Ready ignores the requester's own valid; the other requester's valid and
  // the last winner decide who may proceed.
  assign req0_ready = rst_n && !stall && (!req1_valid || last_grant_reg);
  assign req1_ready = rst_n && !stall && (!req0_valid || !last_grant_reg);

  assign hs0 = req0_valid && req0_ready;
  assign hs1 = req1_valid && req1_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_reg <= 1'b1;
      we_reg         <= 1'b0;
      addr_reg       <= '0;
      data_reg       <= '0;
      grant_reg      <= 1'b0;
    end else begin
      we_reg <= 1'b0;
      if (hs0) begin
        we_reg         <= (req0_addr != '0);
        addr_reg       <= req0_addr;
        data_reg       <= req0_data;
        grant_reg      <= 1'b0;
        last_grant_reg <= 1'b0;
      end else if (hs1) begin
        we_reg         <= (req1_addr != '0);
        addr_reg       <= req1_addr;
        data_reg       <= req1_data;
        grant_reg      <= 1'b1;
        last_grant_reg <= 1'b1;
      end
    end
  end

  assign we          = we_reg;
  assign addr_write2 = addr_reg;
  assign data_write2 = data_reg;
  assign grant_id    = grant_reg;

  logic [AW-1:0] fwd_addr_arr [2];
  logic          fwd_hit_arr  [2];
  logic [N-1:0]  fwd_data_arr [2];

  assign fwd_addr_arr[0] = fwd_addr0;
  assign fwd_addr_arr[1] = fwd_addr1;

  // x0 never forwards, even though a filtered write still loads addr_write2.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      assign fwd_hit_arr[gi]  = we_reg && (fwd_addr_arr[gi] == addr_reg) &&
                                (fwd_addr_arr[gi] != '0);
      assign fwd_data_arr[gi] = fwd_hit_arr[gi] ? data_reg : '0;
    end
  endgenerate

  assign fwd_hit0  = fwd_hit_arr[0];
  assign fwd_hit1  = fwd_hit_arr[1];
  assign fwd_data0 = fwd_data_arr[0];
  assign fwd_data1 = fwd_data_arr[1];

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: each driven cycle pushes its predicted
// write-stage result to a scoreboard that is popped after the following edge.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        req0_valid, req1_valid;
  logic [4:0]  req0_addr, req1_addr;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        we;
  logic [4:0]  addr_write2;
  logic [31:0] data_write2;
  logic        grant_id;
  logic [4:0]  fwd_addr0, fwd_addr1;
  logic        fwd_hit0, fwd_hit1;
  logic [31:0] fwd_data0, fwd_data1;

  regfile_write_arbiter dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data),
    .req1_ready(req1_ready),
    .we(we), .addr_write2(addr_write2), .data_write2(data_write2),
    .grant_id(grant_id),
    .fwd_addr0(fwd_addr0), .fwd_addr1(fwd_addr1),
    .fwd_hit0(fwd_hit0), .fwd_hit1(fwd_hit1),
    .fwd_data0(fwd_data0), .fwd_data1(fwd_data1)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        gid;
  } exp_t;

  exp_t sb[$];
  exp_t last_popped;

  int n_checks = 0;
  int n_errors = 0;

  logic        m_last;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic        m_gid;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_last = 1'b1;
    m_addr = '0;
    m_data = '0;
    m_gid  = 1'b0;
    sb.delete();
  endtask

  // Drive one cycle, check readies mid-cycle, then check the write stage after the edge.
  task automatic step(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                      input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                      input logic st);
    logic r0, r1;
    exp_t e;
    logic h0, h1;
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    stall = st;
    #2;
    r0 = !st && (!v1 || m_last);
    r1 = !st && (!v0 || !m_last);
    check("req0_ready", {31'b0, req0_ready}, {31'b0, r0});
    check("req1_ready", {31'b0, req1_ready}, {31'b0, r1});
    e.we = 1'b0;
    if (v0 && r0) begin
      e.we = (a0 != 0); m_addr = a0; m_data = d0; m_gid = 1'b0; m_last = 1'b0;
    end else if (v1 && r1) begin
      e.we = (a1 != 0); m_addr = a1; m_data = d1; m_gid = 1'b1; m_last = 1'b1;
    end
    e.addr = m_addr; e.data = m_data; e.gid = m_gid;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      last_popped = e;
      check("we", {31'b0, we}, {31'b0, e.we});
      check("addr_write2", {27'b0, addr_write2}, {27'b0, e.addr});
      check("data_write2", data_write2, e.data);
      check("grant_id", {31'b0, grant_id}, {31'b0, e.gid});
      h0 = e.we && (fwd_addr0 == e.addr) && (fwd_addr0 != 0);
      h1 = e.we && (fwd_addr1 == e.addr) && (fwd_addr1 != 0);
      check("fwd_hit0", {31'b0, fwd_hit0}, {31'b0, h0});
      check("fwd_hit1", {31'b0, fwd_hit1}, {31'b0, h1});
      check("fwd_data0", fwd_data0, h0 ? e.data : 32'h0);
      check("fwd_data1", fwd_data1, h1 ? e.data : 32'h0);
    end
    h0 = 1'b0; h1 = 1'b0;
  endtask

  logic [3:0] exp_gids;

  initial begin
    rst_n = 1'b0; stall = 1'b0;
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
    fwd_addr0 = '0; fwd_addr1 = '0;
    model_reset();

    // Reset state: readies held low even with valid requests.
    @(posedge clk); #1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("rst_req0_ready", {31'b0, req0_ready}, 32'd0);
    check("rst_req1_ready", {31'b0, req1_ready}, 32'd0);
    check("rst_we", {31'b0, we}, 32'd0);
    check("rst_addr", {27'b0, addr_write2}, 32'd0);
    check("rst_data", data_write2, 32'd0);
    check("rst_gid", {31'b0, grant_id}, 32'd0);
    rst_n = 1'b1;
    $display("reset released");

    // Single req0 write.
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b0);
    check("t1_we", {31'b0, we}, 32'd1);
    check("t1_addr", {27'b0, addr_write2}, 32'd5);
    check("t1_data", data_write2, 32'hDEADBEEF);
    $display("txn req0 addr=5 data=deadbeef -> we=%0d addr=%0d gid=%0d", we, addr_write2, grant_id);

    // x0 write by req1: handshake completes, no write enable, no forwarding.
    fwd_addr0 = 5'd0;
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0);
    check("x0_we", {31'b0, we}, 32'd0);
    check("x0_fwd_hit0", {31'b0, fwd_hit0}, 32'd0);
    check("x0_data_loaded", data_write2, 32'hFFFFFFFF);
    $display("txn req1 addr=0 -> we=%0d gid=%0d", we, grant_id);

    // Continuous contention alternates starting with req0.
    exp_gids = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b0);
      check("rr_gid", {31'b0, grant_id}, {31'b0, exp_gids[i]});
      check("rr_addr", {27'b0, addr_write2}, exp_gids[i] ? 32'd2 : 32'd1);
      $display("txn contention %0d -> gid=%0d addr=%0d we=%0d", i, grant_id, addr_write2, we);
    end

    // Stall with both pending, then resume from unchanged last_grant.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 1'b1);
      $display("txn stall %0d -> we=%0d", i, we);
    end
    step(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 1'b0);
    check("stall_resume_gid", {31'b0, grant_id}, 32'd0);
    $display("txn stall release -> gid=%0d", grant_id);
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h44, 1'b0);
    $display("txn req1 drains -> gid=%0d addr=%0d", grant_id, addr_write2);

    // Forwarding of an in-flight write.
    fwd_addr0 = 5'd7; fwd_addr1 = 5'd8;
    step(1'b1, 5'd7, 32'h1234, 1'b0, 5'd0, 32'h0, 1'b0);
    check("fwd_t_hit0", {31'b0, fwd_hit0}, 32'd1);
    check("fwd_t_data0", fwd_data0, 32'h1234);
    check("fwd_t_hit1", {31'b0, fwd_hit1}, 32'd0);
    check("fwd_t_data1", fwd_data1, 32'h0);
    $display("txn fwd addr=7 -> hit0=%0d data0=%h hit1=%0d", fwd_hit0, fwd_data0, fwd_hit1);

    // Same address from both: req1 wins (last was req0), req0 lands later.
    fwd_addr0 = 5'd10; fwd_addr1 = 5'd0;
    step(1'b1, 5'd10, 32'hAAAA, 1'b1, 5'd10, 32'hBBBB, 1'b0);
    check("same_first", data_write2, 32'hBBBB);
    step(1'b1, 5'd10, 32'hAAAA, 1'b0, 5'd0, 32'h0, 1'b0);
    check("same_final", data_write2, 32'hAAAA);
    $display("txn same-addr -> final data=%h gid=%0d", data_write2, grant_id);

    // Asynchronous reset while a write is in flight.
    fwd_addr0 = 5'd9;
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99, 1'b0);
    check("pre_arst_we", {31'b0, we}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_we", {31'b0, we}, 32'd0);
    check("arst_addr", {27'b0, addr_write2}, 32'd0);
    check("arst_fwd_hit0", {31'b0, fwd_hit0}, 32'd0);
    check("arst_req1_ready", {31'b0, req1_ready}, 32'd0);
    #1 rst_n = 1'b1;
    model_reset();
    $display("txn async reset -> we=%0d", we);
    step(1'b1, 5'd6, 32'h66, 1'b1, 5'd12, 32'hCC, 1'b0);
    check("post_arst_gid", {31'b0, grant_id}, 32'd0);
    $display("txn post-reset conflict -> gid=%0d addr=%0d", grant_id, addr_write2);
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    $display("txn idle -> we=%0d", we);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
